// File: rtl/rgbw_pwm_generator.sv
// Four-channel RGBW PWM generator: one shared period counter advanced on rising
// edges of the prescaled clock, with double-buffered duty values applied at wrap.
module rgbw_pwm_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkPresc,
    input  logic             dutyWe,
    input  logic [WIDTH-1:0] dutyR,
    input  logic [WIDTH-1:0] dutyG,
    input  logic [WIDTH-1:0] dutyB,
    input  logic [WIDTH-1:0] dutyW,
    output logic             pwmR,
    output logic             pwmG,
    output logic             pwmB,
    output logic             pwmW,
    output logic             periodStart,
    output logic             updatePending
);

    localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};

    // Channel index order throughout: 0=R, 1=G, 2=B, 3=W.
    logic                  prev_q, prev_d;
    logic [WIDTH-1:0]      cnt_q, cnt_d;
    logic [3:0][WIDTH-1:0] stage_q, stage_d;
    logic [3:0][WIDTH-1:0] shadow_q, shadow_d;
    logic [3:0]            pwm_q, pwm_d;
    logic                  period_start_q, period_start_d;
    logic                  update_pending_q, update_pending_d;

    logic tick;
    logic wrap;

    always_comb begin
        tick           = clkPresc & ~prev_q;
        wrap           = tick & (cnt_q == MAX_CNT);
        prev_d         = clkPresc;
        cnt_d          = tick ? cnt_q + WIDTH'(1) : cnt_q;
        period_start_d = wrap;

        // NOTE: every combinational output gets a default first, so no path
        // through this block leaves a variable unassigned and infers a latch.
        stage_d          = stage_q;
        shadow_d         = shadow_q;
        update_pending_d = update_pending_q;

        // Shadow takes the pre-write staging value; a coincident write is then
        // captured into staging and keeps the update pending for the next wrap.
        if (wrap && update_pending_q) begin
            shadow_d         = stage_q;
            update_pending_d = 1'b0;
        end
        if (dutyWe) begin
            stage_d          = {dutyW, dutyB, dutyG, dutyR};
            update_pending_d = 1'b1;
        end

        for (int i = 0; i < 4; i++) begin
            pwm_d[i] = (cnt_q < shadow_q[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q           <= 1'b0;
            cnt_q            <= '0;
            stage_q          <= '0;
            shadow_q         <= '0;
            pwm_q            <= '0;
            period_start_q   <= 1'b0;
            update_pending_q <= 1'b0;
        end else begin
            prev_q           <= prev_d;
            cnt_q            <= cnt_d;
            stage_q          <= stage_d;
            shadow_q         <= shadow_d;
            pwm_q            <= pwm_d;
            period_start_q   <= period_start_d;
            update_pending_q <= update_pending_d;
        end
    end

    assign pwmR          = pwm_q[0];
    assign pwmG          = pwm_q[1];
    assign pwmB          = pwm_q[2];
    assign pwmW          = pwm_q[3];
    assign periodStart   = period_start_q;
    assign updatePending = update_pending_q;

endmodule

// File: tb/tb_rgbw_pwm_generator.sv
// Scoreboard bench for rgbw_pwm_generator: the stimulus side predicts per-period
// high-tick counts and pending state; a monitor measures the DUT and compares.
module tb_rgbw_pwm_generator;

    localparam int PERIOD = 256;

    typedef logic [3:0][7:0] quad_t;  // 0=R, 1=G, 2=B, 3=W

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clkPresc = 1'b0;
    logic dutyWe = 1'b0;
    logic [7:0] dutyR = '0, dutyG = '0, dutyB = '0, dutyW = '0;
    logic pwmR, pwmG, pwmB, pwmW, periodStart, updatePending;

    rgbw_pwm_generator #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .clkPresc(clkPresc), .dutyWe(dutyWe),
        .dutyR(dutyR), .dutyG(dutyG), .dutyB(dutyB), .dutyW(dutyW),
        .pwmR(pwmR), .pwmG(pwmG), .pwmB(pwmB), .pwmW(pwmW),
        .periodStart(periodStart), .updatePending(updatePending)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: tick position within the period and the duty set in
    // force for the current period, staged duties and whether they are waiting.
    int    m_pos = 0;
    bit    m_prev = 1'b0;
    bit    m_pending = 1'b0;
    quad_t m_staged = '0;
    quad_t m_applied = '0;
    int    ph = 0;

    quad_t exp_q[$];   // expected high-tick count per channel for each finished period
    bit    pend_q[$];  // expected updatePending after each clock edge

    task automatic step(input bit rn, input bit presc, input bit we, input quad_t d);
        @(negedge clk);
        reset    = rn;
        clkPresc = presc;
        dutyWe   = we;
        dutyR    = d[0];
        dutyG    = d[1];
        dutyB    = d[2];
        dutyW    = d[3];
        if (!rn) begin
            m_pos = 0; m_prev = 1'b0; m_pending = 1'b0;
            m_staged = '0; m_applied = '0;
        end else begin
            if (presc && !m_prev) begin
                if (m_pos == PERIOD - 1) begin
                    exp_q.push_back(m_applied);
                    if (m_pending) begin
                        m_applied = m_staged;
                        m_pending = 1'b0;
                    end
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            m_prev = presc;
            if (we) begin
                m_staged  = d;
                m_pending = 1'b1;
            end
        end
        pend_q.push_back(m_pending);
    endtask

    // Standard divider: clkPresc toggles every 2 clk, so one tick per 4 clk.
    task automatic std_step(input bit we, input quad_t d);
        ph++;
        step(1'b1, ph[1], we, d);
    endtask

    task automatic idle(input int n);
        repeat (n) std_step(1'b0, '0);
    endtask

    function automatic bit wrap_next();
        int nph = ph + 1;
        return nph[1] && !m_prev && (m_pos == PERIOD - 1);
    endfunction

    task automatic run_to_pos(input int p);
        for (int i = 0; i < 5000 && m_pos != p; i++) std_step(1'b0, '0);
    endtask

    task automatic run_to_wrap_edge();
        for (int i = 0; i < 5000 && !wrap_next(); i++) std_step(1'b0, '0);
    endtask

    // Monitor: samples just after each edge. Right after a tick edge the outputs
    // still show the count before that tick, so one sample per tick per period.
    int         acc[4];
    int         samples = 0;
    bit         mon_prev = 1'b0;
    bit         mon_prev_tick = 1'b0;
    bit         tick_now;
    logic [3:0] last_pwm = '0;
    logic [3:0] pwm_now;
    quad_t      e;

    initial begin
        foreach (acc[c]) acc[c] = 0;
        forever begin
            @(posedge clk);
            #1;
            pwm_now = {pwmW, pwmB, pwmG, pwmR};
            if (pend_q.size() > 0) check("update_pending", updatePending, pend_q.pop_front());
            if (!reset) begin
                check("reset_pwm", pwm_now, 0);
                check("reset_period_start", periodStart, 0);
                foreach (acc[c]) acc[c] = 0;
                samples = 0; mon_prev = 1'b0; mon_prev_tick = 1'b0; last_pwm = '0;
            end else begin
                tick_now = clkPresc && !mon_prev;
                mon_prev = clkPresc;
                if (!mon_prev_tick) check("pwm_hold_between_ticks", pwm_now, last_pwm);
                if (tick_now) begin
                    foreach (acc[c]) acc[c] += int'(pwm_now[c]);
                    samples++;
                end
                if (periodStart === 1'b1) begin
                    check("period_start_on_tick", tick_now, 1);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_period_start: got pulse, expected none (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("high_ticks_R", acc[0], e[0]);
                        check("high_ticks_G", acc[1], e[1]);
                        check("high_ticks_B", acc[2], e[2]);
                        check("high_ticks_W", acc[3], e[3]);
                        check("period_ticks", samples, PERIOD);
                    end
                    foreach (acc[c]) acc[c] = 0;
                    samples = 0;
                end
                mon_prev_tick = tick_now;
                last_pwm = pwm_now;
            end
        end
    end

    quad_t d;

    initial begin
        // Reset for 3 clk with clkPresc toggling, then idle with no writes.
        for (int i = 0; i < 3; i++) begin
            ph++;
            step(1'b0, ph[1], 1'b0, '0);
        end
        idle(2048);

        // Basic duties R=64, G=0, B=255, W=128.
        d = {8'd128, 8'd255, 8'd0, 8'd64};
        std_step(1'b1, d);
        idle(2100);

        // Mid-period update R=200 keeps 64 this period, 200 the next.
        run_to_pos(100);
        d[0] = 8'd200;
        std_step(1'b1, d);
        idle(1200);

        // Two writes before one wrap: last write wins.
        run_to_pos(40);
        d[0] = 8'd10;
        std_step(1'b1, d);
        idle(50);
        d[0] = 8'd20;
        std_step(1'b1, d);
        idle(1200);

        // Write coincident with the wrap tick: old staging applies now, the new
        // value one period later.
        run_to_pos(60);
        d[0] = 8'd150;
        std_step(1'b1, d);
        run_to_wrap_edge();
        d[0] = 8'd77;
        std_step(1'b1, d);
        idle(2100);

        // Freeze with clkPresc held high mid-period, then resume.
        run_to_pos(30);
        while (ph[1] == 1'b0) std_step(1'b0, '0);
        repeat (500) step(1'b1, 1'b1, 1'b0, '0);
        idle(1100);

        // Reset mid-operation with R=128 active, then zero outputs until rewrite.
        d = {8'd3, 8'd90, 8'd200, 8'd128};
        std_step(1'b1, d);
        idle(1100);
        run_to_pos(50);
        step(1'b0, 1'b0, 1'b0, '0);
        idle(1100);
        d = {8'd255, 8'd1, 8'd128, 8'd33};
        std_step(1'b1, d);
        idle(2100);

        // Randomised clkPresc and writes at random times with random duties.
        for (int i = 0; i < 8000; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0), quad_t'($urandom));
        end
        idle(20);

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        check("pending_queue_drained", pend_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
